digit_sprite_renderer: RTL

Parametrised multi-digit numeric overlay for the VGA pixel path (score, timer, bomb counts). It converts a binary value to BCD with an iterative shift-and-add-3 engine and holds the result in a shadow register. It then renders NUM_DIGITS glyphs of 32x24 pixels from a shared 10-glyph 2-bit-code ROM with a programmable palette. Pixel lookups run through a fixed 2-cycle pipeline, so the block sits between the VGA coordinate generator and the final colour mux.

---
 rtl/digit_sprite_pkg.sv | 50 +++++
 rtl/digit_glyph_rom.sv | 82 ++++++++
 rtl/digit_sprite_renderer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/digit_sprite_pkg.sv
// Shared types, constants and small helpers for the numeric digit overlay.
// Glyph cells are 32x24 pixels, 2-bit codes per pixel.
package digit_sprite_pkg;

  localparam int GLYPH_W     = 32;
  localparam int GLYPH_H     = 24;
  localparam int COLOR_W_DEF = 10;

  localparam logic [9:0] DEF_OUTLINE_COLOR = 10'd430;
  localparam logic [9:0] DEF_FILL_COLOR    = 10'd428;

  typedef enum logic [1:0] {
    TRANSP  = 2'd0,
    OUTLINE = 2'd1,
    FILL    = 2'd2,
    RSVD    = 2'd3
  } pix_code_t;

  typedef enum logic [1:0] {
    CONV_IDLE   = 2'd0,
    CONV_SHIFT  = 2'd1,
    CONV_COMMIT = 2'd2
  } conv_state_t;

  // Seven-segment enables, bit 0 = segment a ... bit 6 = segment g
  function automatic logic [6:0] seg_map(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_map = 7'b011_1111;
      4'd1:    seg_map = 7'b000_0110;
      4'd2:    seg_map = 7'b101_1011;
      4'd3:    seg_map = 7'b100_1111;
      4'd4:    seg_map = 7'b110_0110;
      4'd5:    seg_map = 7'b110_1101;
      4'd6:    seg_map = 7'b111_1101;
      4'd7:    seg_map = 7'b000_0111;
      4'd8:    seg_map = 7'b111_1111;
      4'd9:    seg_map = 7'b110_1111;
      default: seg_map = 7'b000_0000;
    endcase
  endfunction

  function automatic logic [3:0] bcd_add3(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      bcd_add3 = nib + 4'd3;
    end else begin
      bcd_add3 = nib;
    end
  endfunction

endpackage

// File: rtl/digit_glyph_rom.sv
// Ten-glyph 32x24 code ROM with a registered 2-bit output.
// Glyphs are outlined seven-segment bars; everything else is transparent.
module digit_glyph_rom
  import digit_sprite_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit_i,
  input  logic [4:0] row_i,
  input  logic [4:0] col_i,
  output pix_code_t  code_o
);

  typedef struct packed {
    logic [4:0] c0;
    logic [4:0] c1;
    logic [4:0] r0;
    logic [4:0] r1;
  } box_t;

  // Outer bounding box of each bar (inclusive); the 1-pixel rim is outline.
  function automatic box_t seg_box(input logic [2:0] seg);
    case (seg)
      3'd0:    seg_box = '{c0: 5'd2,  c1: 5'd23, r0: 5'd0,  r1: 5'd4};
      3'd1:    seg_box = '{c0: 5'd19, c1: 5'd25, r0: 5'd2,  r1: 5'd12};
      3'd2:    seg_box = '{c0: 5'd19, c1: 5'd25, r0: 5'd11, r1: 5'd21};
      3'd3:    seg_box = '{c0: 5'd2,  c1: 5'd23, r0: 5'd19, r1: 5'd23};
      3'd4:    seg_box = '{c0: 5'd0,  c1: 5'd6,  r0: 5'd11, r1: 5'd21};
      3'd5:    seg_box = '{c0: 5'd0,  c1: 5'd6,  r0: 5'd2,  r1: 5'd12};
      3'd6:    seg_box = '{c0: 5'd2,  c1: 5'd23, r0: 5'd10, r1: 5'd14};
      default: seg_box = '{c0: 5'd0,  c1: 5'd0,  r0: 5'd0,  r1: 5'd0};
    endcase
  endfunction

  logic [6:0] segs_s;
  box_t       box_s;
  logic       any_fill_s;
  logic       any_edge_s;
  pix_code_t  code_d;
  pix_code_t  code_q;

  // Fill wins over outline where bars overlap
  always_comb begin
    segs_s     = seg_map(digit_i);
    box_s      = '0;
    any_fill_s = 1'b0;
    any_edge_s = 1'b0;
    for (int s = 0; s < 7; s++) begin
      box_s = seg_box(3'(s));
      if (segs_s[s] && col_i >= box_s.c0 && col_i <= box_s.c1 &&
          row_i >= box_s.r0 && row_i <= box_s.r1) begin
        any_edge_s = 1'b1;
        if (col_i > box_s.c0 && col_i < box_s.c1 &&
            row_i > box_s.r0 && row_i < box_s.r1) begin
          any_fill_s = 1'b1;
        end else begin
          any_fill_s = any_fill_s;
        end
      end else begin
        any_edge_s = any_edge_s;
      end
    end
    if (any_fill_s) begin
      code_d = FILL;
    end else if (any_edge_s) begin
      code_d = OUTLINE;
    end else begin
      code_d = TRANSP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q <= TRANSP;
    end else begin
      code_q <= code_d;
    end
  end

  assign code_o = code_q;

endmodule

// File: rtl/digit_sprite_renderer.sv
// Multi-digit numeric overlay: binary-to-BCD converter with a shadow display
// register, followed by a fixed 2-cycle glyph lookup pipeline.
module digit_sprite_renderer
  import digit_sprite_pkg::*;
#(
  parameter int NUM_DIGITS = 3,
  parameter int VALUE_W    = 10,
  parameter bit BLANK_LZ   = 1'b1,
  parameter int COLOR_W    = COLOR_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [VALUE_W-1:0] value_i,
  output logic               busy_o,
  input  logic [9:0]         org_x_i,
  input  logic [9:0]         org_y_i,
  input  logic [COLOR_W-1:0] outline_color_i,
  input  logic [COLOR_W-1:0] fill_color_i,
  input  logic               pix_valid_i,
  input  logic [9:0]         pix_x_i,
  input  logic [9:0]         pix_y_i,
  output logic               pix_valid_o,
  output logic               pix_hit_o,
  output logic [COLOR_W-1:0] pix_rgb_o
);

  localparam int     BCD_W   = 4 * NUM_DIGITS;
  localparam int     CNT_W   = $clog2(VALUE_W + 1);
  localparam int     WIN_W   = NUM_DIGITS * GLYPH_W;
  localparam longint MAX_VAL = longint'(10 ** NUM_DIGITS - 1);

  conv_state_t        state_q, state_d;
  logic [VALUE_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0]   work_q, work_d;
  logic [BCD_W-1:0]   add3_s;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               busy_q;

  // Converter: a fresh load always restarts, whatever the current state
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    add3_s  = work_q;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      add3_s[d*4 +: 4] = bcd_add3(work_q[d*4 +: 4]);
    end
    if (load_i) begin
      state_d = CONV_SHIFT;
      work_d  = '0;
      cnt_d   = '0;
      if (64'(value_i) > 64'(MAX_VAL)) begin
        bin_d = VALUE_W'(MAX_VAL);
      end else begin
        bin_d = value_i;
      end
    end else begin
      case (state_q)
        CONV_IDLE: begin
          state_d = CONV_IDLE;
        end
        CONV_SHIFT: begin
          work_d = {add3_s[BCD_W-2:0], bin_q[VALUE_W-1]};
          bin_d  = bin_q << 1;
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(VALUE_W - 1)) begin
            state_d = CONV_COMMIT;
          end else begin
            state_d = CONV_SHIFT;
          end
        end
        CONV_COMMIT: begin
          disp_d  = work_q;
          state_d = CONV_IDLE;
        end
        default: begin
          state_d = CONV_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CONV_IDLE;
      bin_q   <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      busy_q  <= (state_d != CONV_IDLE);
    end
  end

  assign busy_o = busy_q;

  logic signed [10:0] dx_s, dy_s;
  logic               in_win_s;
  logic [2:0]         slot_s;
  logic [3:0]         nib_s;
  logic               lead_zero_s;
  logic [3:0]         slot_digit_s;
  logic               blank_s;

  // Geometry and leading-zero blanking; slot 0 is the most significant digit
  always_comb begin
    dx_s     = $signed({1'b0, pix_x_i}) - $signed({1'b0, org_x_i});
    dy_s     = $signed({1'b0, pix_y_i}) - $signed({1'b0, org_y_i});
    in_win_s = !dx_s[10] && (dx_s[9:0] < 10'(WIN_W)) &&
               !dy_s[10] && (dy_s[9:0] < 10'(GLYPH_H));
    slot_s       = dx_s[7:5];
    nib_s        = 4'd0;
    lead_zero_s  = 1'b1;
    slot_digit_s = 4'd0;
    blank_s      = 1'b0;
    for (int s = 0; s < NUM_DIGITS; s++) begin
      nib_s       = disp_q[(NUM_DIGITS-1-s)*4 +: 4];
      lead_zero_s = lead_zero_s && (nib_s == 4'd0);
      if (slot_s == 3'(s)) begin
        slot_digit_s = nib_s;
        blank_s      = BLANK_LZ && lead_zero_s && (s != NUM_DIGITS - 1);
      end else begin
        slot_digit_s = slot_digit_s;
      end
    end
  end

  logic               s1_valid_q, s1_en_q;
  logic [3:0]         s1_digit_q;
  logic [4:0]         s1_row_q, s1_col_q;
  logic [COLOR_W-1:0] s1_outline_q, s1_fill_q;
  logic               s2_valid_q, s2_en_q;
  logic [COLOR_W-1:0] s2_outline_q, s2_fill_q;
  pix_code_t          s2_code_s;

  // Stage 1: palette is captured with its pixel so it stays aligned
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_en_q      <= 1'b0;
      s1_digit_q   <= 4'd0;
      s1_row_q     <= 5'd0;
      s1_col_q     <= 5'd0;
      s1_outline_q <= '0;
      s1_fill_q    <= '0;
    end else begin
      s1_valid_q   <= pix_valid_i;
      s1_en_q      <= in_win_s && !blank_s;
      s1_digit_q   <= slot_digit_s;
      s1_row_q     <= dy_s[4:0];
      s1_col_q     <= dx_s[4:0];
      s1_outline_q <= outline_color_i;
      s1_fill_q    <= fill_color_i;
    end
  end

  digit_glyph_rom u_rom (
    .clk     (clk),
    .rst_n   (rst_n),
    .digit_i (s1_digit_q),
    .row_i   (s1_row_q),
    .col_i   (s1_col_q),
    .code_o  (s2_code_s)
  );

  // Stage 2 side-band registered alongside the ROM code
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q   <= 1'b0;
      s2_en_q      <= 1'b0;
      s2_outline_q <= '0;
      s2_fill_q    <= '0;
    end else begin
      s2_valid_q   <= s1_valid_q;
      s2_en_q      <= s1_en_q;
      s2_outline_q <= s1_outline_q;
      s2_fill_q    <= s1_fill_q;
    end
  end

  assign pix_valid_o = s2_valid_q;

  // Palette mux; the reserved code renders as outline
  always_comb begin
    pix_hit_o = 1'b0;
    pix_rgb_o = '0;
    if (s2_en_q) begin
      case (s2_code_s)
        OUTLINE, RSVD: begin
          pix_hit_o = 1'b1;
          pix_rgb_o = s2_outline_q;
        end
        FILL: begin
          pix_hit_o = 1'b1;
          pix_rgb_o = s2_fill_q;
        end
        default: begin
          pix_hit_o = 1'b0;
          pix_rgb_o = '0;
        end
      endcase
    end else begin
      pix_hit_o = 1'b0;
      pix_rgb_o = '0;
    end
  end

endmodule
